// File: rtl/z80_rom_wait_ctrl_pkg.sv
// Shared types and constants for the Z80 ROM wait-state controller.
// The Z80_ROM_TIMEOUT_EN macro enables the fetch timeout and the ROM_ERR flag.
package z80_rom_wait_ctrl_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned ROM_ADDR_W = 15;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned TMO_CNT_W  = 8;
    localparam int unsigned STATE_W    = 2;

    localparam logic [ADDR_W-1:0] ROM_END_DEFAULT = 16'h5FFF;
    localparam int unsigned       TIMEOUT_DEFAULT = 255;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } rom_state_e;

    // Plain-vector aliases of the enum values used by the FSM register.
    localparam logic [STATE_W-1:0] ST_IDLE = IDLE;
    localparam logic [STATE_W-1:0] ST_REQ  = REQ;
    localparam logic [STATE_W-1:0] ST_HOLD = HOLD;

    // True when a CPU address falls inside the window served by this block.
    function automatic logic in_rom(input logic [ADDR_W-1:0] adrs,
                                    input logic [ADDR_W-1:0] rom_end);
        return adrs <= rom_end;
    endfunction

endpackage

// File: rtl/z80_rom_wait_ctrl_if.sv
// CPU bus and external ROM port bundle for the Z80 ROM wait-state controller.
// ROM_ERR exists only when Z80_ROM_TIMEOUT_EN is defined.
interface z80_rom_wait_ctrl_if
    import z80_rom_wait_ctrl_pkg::*;
();

    // CPU side
    logic [ADDR_W-1:0]     adrs;
    logic                  mreq_n;
    logic                  rd_n;
    logic                  rfsh_n;
    logic                  wait_n;
    logic [DATA_W-1:0]     dout;
    logic                  rom_sel;

    // External ROM side
    logic                  rom_req;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic                  rom_ack;
    logic [DATA_W-1:0]     rom_data;
`ifdef Z80_ROM_TIMEOUT_EN
    logic                  rom_err;
`endif

    // CPU core plus ROM memory model
    modport master (
        output adrs,
        output mreq_n,
        output rd_n,
        output rfsh_n,
        output rom_ack,
        output rom_data,
        input  wait_n,
        input  dout,
        input  rom_sel,
        input  rom_req,
`ifdef Z80_ROM_TIMEOUT_EN
        input  rom_err,
`endif
        input  rom_addr
    );

    // The wait-state controller itself
    modport slave (
        input  adrs,
        input  mreq_n,
        input  rd_n,
        input  rfsh_n,
        input  rom_ack,
        input  rom_data,
        output wait_n,
        output dout,
        output rom_sel,
        output rom_req,
`ifdef Z80_ROM_TIMEOUT_EN
        output rom_err,
`endif
        output rom_addr
    );

endinterface

// File: rtl/z80_rom_wait_ctrl.sv
// Stretches Z80 reads of the low ROM window with WAIT_N while a byte is fetched
// from external ROM. Define Z80_ROM_TIMEOUT_EN to add the REQ timeout and ROM_ERR.
module z80_rom_wait_ctrl
    import z80_rom_wait_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_END = ROM_END_DEFAULT
`ifdef Z80_ROM_TIMEOUT_EN
  , parameter int unsigned       TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    z80_rom_wait_ctrl_if.slave  bus
);

    logic [STATE_W-1:0]    state_q,    state_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]     dout_q,     dout_d;
    logic                  rom_req_q,  rom_req_d;
    logic                  rom_sel_q,  rom_sel_d;
    logic                  start_c;
    logic                  wait_n_c;

`ifdef Z80_ROM_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic                  rom_err_q, rom_err_d;
    logic                  tmo_hit_c;
`endif

    // Memory read of the ROM window, not a refresh, and no fetch in flight.
    always_comb begin
        start_c = 1'b0;
        start_c = !bus.mreq_n && !bus.rd_n && bus.rfsh_n
                  && in_rom(bus.adrs, ROM_END)
                  && (state_q == ST_IDLE);
    end

    // WAIT_N must drop in the same cycle the read appears, so it is combinational.
    always_comb begin
        wait_n_c = 1'b1;
        if (start_c || (state_q == ST_REQ)) begin
            wait_n_c = 1'b0;
        end
    end

`ifdef Z80_ROM_TIMEOUT_EN
    always_comb begin
        tmo_hit_c = 1'b0;
        tmo_hit_c = (tmo_cnt_q == TMO_LAST);
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        dout_d     = dout_q;
`ifdef Z80_ROM_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        rom_err_d  = rom_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d    = ST_REQ;
                    rom_addr_d = bus.adrs[ROM_ADDR_W-1:0];
`ifdef Z80_ROM_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end

            ST_REQ: begin
                // A bus abort wins over a coincident acknowledge.
                if (bus.mreq_n) begin
                    state_d = ST_IDLE;
                end else if (bus.rom_ack) begin
                    state_d = ST_HOLD;
                    dout_d  = bus.rom_data;
                end
`ifdef Z80_ROM_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    state_d   = ST_HOLD;
                    dout_d    = DATA_W'(8'hFF);
                    rom_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
`endif
            end

            ST_HOLD: begin
                if (bus.mreq_n) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rom_req_d = (state_d == ST_REQ);
        rom_sel_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            dout_q     <= '0;
            rom_req_q  <= 1'b0;
            rom_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            dout_q     <= dout_d;
            rom_req_q  <= rom_req_d;
            rom_sel_q  <= rom_sel_d;
        end
    end

`ifdef Z80_ROM_TIMEOUT_EN
    // REQ cycle counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            rom_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rom_err_q <= rom_err_d;
        end
    end

    assign bus.rom_err = rom_err_q;
`endif

    assign bus.wait_n   = wait_n_c;
    assign bus.dout     = dout_q;
    assign bus.rom_sel  = rom_sel_q;
    assign bus.rom_req  = rom_req_q;
    assign bus.rom_addr = rom_addr_q;

endmodule

// File: tb/tb_z80_rom_wait_ctrl.sv
// Scoreboard bench for z80_rom_wait_ctrl: a driver plays CPU and ROM, a monitor
// checks ROM requests, wait-stretch lengths and latched bytes against queued expectations.
module tb_z80_rom_wait_ctrl;
    import z80_rom_wait_ctrl_pkg::*;

    localparam logic [15:0] ROM_END_T = ROM_END_DEFAULT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    z80_rom_wait_ctrl_if bus();

    z80_rom_wait_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expectations produced by the driver, consumed by the monitor
    logic [14:0] exp_addr_q[$];
    logic [7:0]  exp_dout_q[$];
    int          exp_wait_q[$];
    logic [7:0]  model_dout = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    logic prev_req = 1'b0;
    logic prev_sel = 1'b0;
    int   wcnt     = 0;
    always @(negedge clk) begin
        if (bus.rom_req === 1'b1 && !prev_req) begin
            check("rom_req_pending", 32'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr_q.pop_front()));
        end
        if (bus.rom_sel === 1'b1 && !prev_sel) begin
            check("rom_sel_pending", 32'(exp_dout_q.size() != 0), 1);
            if (exp_dout_q.size() != 0) check("dout", 32'(bus.dout), 32'(exp_dout_q.pop_front()));
        end
        if (bus.wait_n === 1'b0) begin
            wcnt++;
        end else if (wcnt != 0) begin
            check("wait_pending", 32'(exp_wait_q.size() != 0), 1);
            if (exp_wait_q.size() != 0) check("wait_cycles", 32'(wcnt), 32'(exp_wait_q.pop_front()));
            wcnt = 0;
        end
        prev_req = (bus.rom_req === 1'b1);
        prev_sel = (bus.rom_sel === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.rfsh_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        bus.adrs   = a;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        bus.rfsh_n = 1'b1;
    endtask

    // ROM side: wait (bounded) for the fetch request to appear
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.rom_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("rom_req_seen", 32'(ok), 1);
        if (!ok) begin
            exp_addr_q.delete();
            exp_dout_q.delete();
            exp_wait_q.delete();
            bus_idle();
            cyc();
        end
    endtask

    // Normal ROM read: the stretch is the start cycle plus every REQ cycle
    task automatic rom_read(input logic [15:0] a, input int d, input logic [7:0] data, input int hold);
        bit ok;
        exp_addr_q.push_back(a[14:0]);
        exp_wait_q.push_back(d + 2);
        exp_dout_q.push_back(data);
        cpu_read(a);
        wait_req(ok);
        if (ok) begin
            repeat (d) cyc();
            bus.rom_ack  = 1'b1;
            bus.rom_data = data;
            cyc();
            bus.rom_ack  = 1'b0;
            bus.rom_data = 8'($urandom);
            model_dout   = data;
            for (int i = 0; i < hold; i++) begin
                check("hold_sel", 32'(bus.rom_sel), 1);
                check("hold_wait_n", 32'(bus.wait_n), 1);
                cyc();
            end
            bus_idle();
            cyc();
            check("sel_after_hold", 32'(bus.rom_sel), 0);
            check("dout_kept", 32'(bus.dout), 32'(model_dout));
        end
    endtask

    // Access that must never stretch or fetch
    task automatic no_fetch(input logic [15:0] a, input logic rd, input logic rf);
        bus.adrs   = a;
        bus.mreq_n = 1'b0;
        bus.rd_n   = rd;
        bus.rfsh_n = rf;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nf_wait_n", 32'(bus.wait_n), 1);
            check("nf_rom_req", 32'(bus.rom_req), 0);
            cyc();
        end
        bus_idle();
        cyc();
    endtask

    // MREQ_N rises in REQ, then a stray acknowledge arrives
    task automatic abort_read(input logic [15:0] a, input int k, input logic [7:0] data);
        bit ok;
        exp_addr_q.push_back(a[14:0]);
        exp_wait_q.push_back(k + 2);
        cpu_read(a);
        wait_req(ok);
        if (ok) begin
            repeat (k) cyc();
            bus_idle();
            cyc();
            check("abort_rom_req", 32'(bus.rom_req), 0);
            bus.rom_ack  = 1'b1;
            bus.rom_data = data;
            cyc();
            bus.rom_ack  = 1'b0;
            check("abort_dout", 32'(bus.dout), 32'(model_dout));
            check("abort_sel", 32'(bus.rom_sel), 0);
            check("abort_wait_n", 32'(bus.wait_n), 1);
            cyc();
            check("abort_rom_req_late", 32'(bus.rom_req), 0);
        end
    endtask

    // Reset pulse in REQ, then a late acknowledge
    task automatic reset_in_req(input logic [15:0] a, input int k, input logic [7:0] data);
        bit ok;
        exp_addr_q.push_back(a[14:0]);
        exp_wait_q.push_back(k + 1);
        cpu_read(a);
        wait_req(ok);
        if (ok) begin
            repeat (k) cyc();
            rst_n = 1'b0;
            bus_idle();
            #1;
            check("rst_rom_req", 32'(bus.rom_req), 0);
            check("rst_sel", 32'(bus.rom_sel), 0);
            rst_n = 1'b1;
            model_dout = 8'h00;
            cyc();
            bus.rom_ack  = 1'b1;
            bus.rom_data = data;
            cyc();
            bus.rom_ack  = 1'b0;
            check("post_rst_dout", 32'(bus.dout), 0);
            check("post_rst_sel", 32'(bus.rom_sel), 0);
            check("post_rst_rom_req", 32'(bus.rom_req), 0);
            check("post_rst_rom_addr", 32'(bus.rom_addr), 0);
            check("post_rst_wait_n", 32'(bus.wait_n), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.adrs     = 16'h0000;
        bus.rom_ack  = 1'b0;
        bus.rom_data = 8'h00;
        bus_idle();

        // Asynchronous reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("reset_dout", 32'(bus.dout), 0);
        check("reset_sel", 32'(bus.rom_sel), 0);
        check("reset_rom_req", 32'(bus.rom_req), 0);
        check("reset_rom_addr", 32'(bus.rom_addr), 0);
        check("reset_wait_n", 32'(bus.wait_n), 1);
`ifdef Z80_ROM_TIMEOUT_EN
        check("reset_rom_err", 32'(bus.rom_err), 0);
`endif
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Directed cases
        rom_read(16'h0123, 2, 8'hA5, 2);
        no_fetch(16'h7D00, 1'b0, 1'b1);
        no_fetch(16'h0010, 1'b1, 1'b0);
        rom_read(16'h0000, 0, 8'h3C, 1);
        rom_read(16'h0001, 1, 8'hC3, 1);
        reset_in_req(16'h0200, 1, 8'h5A);
        rom_read(16'h0040, 0, 8'h11, 1);
        abort_read(16'h0042, 1, 8'h99);
        rom_read(ROM_END_T, 0, 8'h77, 2);
        no_fetch(ROM_END_T + 16'h0001, 1'b0, 1'b1);
        no_fetch(16'h0100, 1'b1, 1'b1);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1, 2: rom_read(16'($urandom_range(0, int'(ROM_END_T))), $urandom_range(0, 4),
                                  8'($urandom), $urandom_range(1, 3));
                3:       no_fetch(16'($urandom_range(int'(ROM_END_T) + 1, 16'hFFFF)), 1'b0, 1'b1);
                4:       no_fetch(16'($urandom), 1'($urandom), 1'b0);
                5:       no_fetch(16'($urandom_range(0, int'(ROM_END_T))), 1'b1, 1'b1);
                default: abort_read(16'($urandom_range(0, int'(ROM_END_T))), $urandom_range(0, 2),
                                    8'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) cyc();
        end

`ifdef Z80_ROM_TIMEOUT_EN
        // Unanswered fetch: TIMEOUT REQ cycles plus the start cycle
        begin
            bit seen;
            seen = 1'b0;
            exp_addr_q.push_back(15'h0300);
            exp_wait_q.push_back(TIMEOUT_DEFAULT + 1);
            exp_dout_q.push_back(8'hFF);
            cpu_read(16'h0300);
            for (int i = 0; i < 400; i++) begin
                cyc();
                if (bus.rom_sel === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("timeout_seen", 32'(seen), 1);
            check("timeout_dout", 32'(bus.dout), 32'h0FF);
            check("timeout_rom_err", 32'(bus.rom_err), 1);
            check("timeout_wait_n", 32'(bus.wait_n), 1);
            check("timeout_rom_req", 32'(bus.rom_req), 0);
            bus_idle();
            cyc();
            rom_read(16'h0004, 0, 8'h21, 1);
            check("rom_err_sticky", 32'(bus.rom_err), 1);
        end
`endif

        repeat (3) cyc();
        check("addr_queue_empty", 32'(exp_addr_q.size()), 0);
        check("dout_queue_empty", 32'(exp_dout_q.size()), 0);
        check("wait_queue_empty", 32'(exp_wait_q.size()), 0);
        check("final_wait_n", 32'(bus.wait_n), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/z80_rom_wait_ctrl.md
Z80_ROM_WAIT_CTRL -- requirements
Module: z80_rom_wait_ctrl

Interface
REQ-001 Parameter ROM_END, default 16'h5FFF, SHALL set the highest CPU address served by this block; the range starts at 16'h0000.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum REQ-state cycles before the timeout abort when Z80_ROM_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  the single core clock, the same clock that drives the CPU core.
REQ-004 RESET_N  in  1  reset, asynchronous and active-low.
REQ-005 ADRS  in  16  CPU address bus.
REQ-006 MREQ_N, RD_N, RFSH_N  in  1 each  CPU bus strobes, active-low.
REQ-007 WAIT_N  out  1  wait request to the CPU WAIT_N input, active-low.
REQ-008 DOUT  out  8  latched ROM byte, fed to the CPU DINP mux.
REQ-009 ROM_SEL  out  1  high selects DOUT onto CPU DINP.
REQ-010 ROM_REQ  out  1  fetch request to external ROM memory.
REQ-011 ROM_ADDR  out  15  fetch address, ADRS[14:0].
REQ-012 ROM_ACK  in  1  one-cycle pulse meaning ROM_DATA is valid.
REQ-013 ROM_DATA  in  8  external ROM read data.
REQ-014 ROM_ERR  out  1  sticky timeout flag; this port SHALL exist only with Z80_ROM_TIMEOUT_EN defined.

Function
REQ-015 The start condition SHALL be: MREQ_N=0, RD_N=0, RFSH_N=1, ADRS<=ROM_END, and state IDLE.
REQ-016 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-017 In IDLE, when start is true, the block SHALL capture ADRS[14:0] into ROM_ADDR and go to REQ on the next edge.
REQ-018 In REQ, the block SHALL hold ROM_REQ=1; on ROM_ACK=1 it SHALL latch ROM_DATA into DOUT, drop ROM_REQ, and go to HOLD on the same edge.
REQ-019 In HOLD, when MREQ_N=1, the block SHALL return to IDLE.
REQ-020 WAIT_N SHALL be combinational and equal 0 when (IDLE and start) or state is REQ; it SHALL equal 1 otherwise, including in HOLD.
REQ-021 ROM_SEL SHALL be 1 in HOLD and 0 in all other states.
REQ-022 DOUT SHALL keep its value until the next ROM_ACK latch.
REQ-023 ROM_ACK SHALL be ignored in IDLE and HOLD.
REQ-024 If MREQ_N rises while in REQ (bus abort), the block SHALL drop ROM_REQ, go to IDLE, and ignore any later ROM_ACK.
REQ-025 An access with ADRS above ROM_END, a refresh cycle, or a write SHALL never assert WAIT_N=0 or ROM_REQ=1.
REQ-026 Back-to-back reads SHALL each issue exactly one ROM_REQ, because a new start is accepted only after HOLD has exited through MREQ_N=1.
REQ-027 ROM_ACK arriving in the first REQ cycle SHALL give the minimum latency: one wait-extended cycle.

Reset
REQ-028 With RESET_N=0, the block SHALL immediately force state IDLE, ROM_REQ=0, ROM_ADDR=0, DOUT=8'h00, ROM_SEL=0 and ROM_ERR=0; WAIT_N then follows REQ-020.
REQ-029 Reset asserted during REQ SHALL abort the fetch, and any ROM_ACK that follows reset SHALL be discarded.

Configuration
REQ-030 With Z80_ROM_TIMEOUT_EN defined, an 8-bit counter SHALL count REQ cycles.
REQ-031 With Z80_ROM_TIMEOUT_EN defined, reaching TIMEOUT SHALL: load DOUT=8'hFF, drop ROM_REQ, set ROM_ERR=1, and go to HOLD.
REQ-032 ROM_ERR SHALL clear only on reset.
REQ-033 With Z80_ROM_TIMEOUT_EN undefined, there SHALL be no counter and no ROM_ERR port, and REQ SHALL wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE=2'd0, REQ=2'd1, HOLD=2'd2), ROM_END_DEFAULT and TIMEOUT_DEFAULT.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter is inline, guarded by the macro.

Verification
REQ-036 Read ADRS=16'h0123, ROM_ACK 3 cycles after ROM_REQ with ROM_DATA=8'hA5 -> ROM_ADDR=15'h0123, WAIT_N low for 4 cycles, then DOUT=8'hA5 and ROM_SEL=1 until MREQ_N rises.
REQ-037 Read ADRS=16'h7D00 and a refresh cycle at ADRS=16'h0010 -> WAIT_N stays 1 and ROM_REQ stays 0 throughout.
REQ-038 Two back-to-back opcode fetches at 16'h0000 and 16'h0001 -> exactly two ROM_REQ assertions, and DOUT shows each byte in turn.
REQ-039 RESET_N pulsed low during REQ, then ROM_ACK with 8'h5A -> after reset, state IDLE, DOUT=8'h00, ROM_SEL=0.
REQ-040 With Z80_ROM_TIMEOUT_EN defined and ROM_ACK never asserted -> after 255 REQ cycles, DOUT=8'hFF, ROM_ERR=1, WAIT_N=1.
REQ-041 MREQ_N rises during REQ, then ROM_ACK arrives -> ROM_REQ drops, state IDLE, DOUT unchanged.
